axi_addr_aligner: RTL and testbench

// - Alignment checker and AXI4-Lite write-strobe generator for the UART-AXI4 bridge master.
// - Combinational: classifies (addr, size) as aligned, misaligned or invalid-size, emits wstrb and a status code in the same cycle.
// - Clocked: optional error-statistics block (sticky flag, saturating count, last failing address) for debug/CSR readout.

---
 rtl/axi_addr_aligner_if.sv | 32 +++
 rtl/axi_addr_aligner.sv | 114 +++++++++++
 tb/tb_axi_addr_aligner.sv | 127 ++++++++++++
 3 files changed

// File: rtl/axi_addr_aligner_if.sv
// Bus bundle for axi_addr_aligner: beat address/size in, alignment verdict,
// write strobes and debug statistics out.
interface axi_addr_aligner_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
);
  logic [ADDR_WIDTH-1:0] addr;
  logic [1:0]            size;
  logic                  check_valid;
  logic                  stats_clear;
  logic                  addr_ok;
  logic [3:0]            wstrb;
  logic [2:0]            status_code;
  logic                  err_sticky;
  logic [CNT_WIDTH-1:0]  err_count;
  logic [ADDR_WIDTH-1:0] last_err_addr;
  logic [2:0]            last_err_status;

  // Driver side (bridge master).
  modport master (
    output addr, size, check_valid, stats_clear,
    input  addr_ok, wstrb, status_code,
    input  err_sticky, err_count, last_err_addr, last_err_status
  );

  // Checker side.
  modport slave (
    input  addr, size, check_valid, stats_clear,
    output addr_ok, wstrb, status_code,
    output err_sticky, err_count, last_err_addr, last_err_status
  );
endinterface

// File: rtl/axi_addr_aligner.sv
// Alignment checker and AXI4-Lite write-strobe generator.
// Combinational verdict/strobes; optional error statistics enabled by
// defining ADDR_ALIGN_STATS_EN (otherwise statistics outputs read 0).
module axi_addr_aligner #(
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input logic                clk,
  input logic                rst,
  axi_addr_aligner_if.slave  bus
);

  localparam logic [2:0] ST_OK    = 3'd0;
  localparam logic [2:0] ST_SIZE  = 3'd2;
  localparam logic [2:0] ST_ALIGN = 3'd3;

  logic       ok_c;
  logic [3:0] strb_c;
  logic [2:0] st_c;

  // Classify (addr, size) and build byte-lane strobes; zero latency.
  always_comb begin
    ok_c   = 1'b0;
    strb_c = 4'b0000;
    st_c   = ST_OK;
    unique case (bus.size)
      2'b00: begin
        ok_c   = 1'b1;
        strb_c = 4'b0001 << bus.addr[1:0];
      end
      2'b01: begin
        if (!bus.addr[0]) begin
          ok_c   = 1'b1;
          strb_c = bus.addr[1] ? 4'b1100 : 4'b0011;
        end else begin
          st_c = ST_ALIGN;
        end
      end
      2'b10: begin
        if (bus.addr[1:0] == 2'b00) begin
          ok_c   = 1'b1;
          strb_c = 4'b1111;
        end else begin
          st_c = ST_ALIGN;
        end
      end
      default: st_c = ST_SIZE;
    endcase
  end

  assign bus.addr_ok     = ok_c;
  assign bus.wstrb       = strb_c;
  assign bus.status_code = st_c;

`ifdef ADDR_ALIGN_STATS_EN
  logic                  sticky_q, sticky_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] laddr_q, laddr_d;
  logic [2:0]            lst_q, lst_d;
  logic                  fail;

  assign fail = bus.check_valid && !ok_c;

  // Next-state for statistics: clear wins over a same-cycle failure.
  always_comb begin
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    laddr_d  = laddr_q;
    lst_d    = lst_q;
    if (bus.stats_clear) begin
      sticky_d = 1'b0;
      cnt_d    = '0;
      laddr_d  = '0;
      lst_d    = '0;
    end else if (fail) begin
      sticky_d = 1'b1;
      if (cnt_q != {CNT_WIDTH{1'b1}}) cnt_d = cnt_q + 1'b1;
      laddr_d  = bus.addr;
      lst_d    = st_c;
    end
  end

  // Statistics registers; reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_q <= 1'b0;
      cnt_q    <= '0;
      laddr_q  <= '0;
      lst_q    <= '0;
    end else begin
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
      laddr_q  <= laddr_d;
      lst_q    <= lst_d;
    end
  end

  assign bus.err_sticky      = sticky_q;
  assign bus.err_count       = cnt_q;
  assign bus.last_err_addr   = laddr_q;
  assign bus.last_err_status = lst_q;
`else
  // Statistics compiled out: outputs tied low, clocking inputs ignored.
  logic unused_stats;
  assign unused_stats = ^{clk, rst, bus.check_valid, bus.stats_clear,
                          bus.addr[ADDR_WIDTH-1:2]};

  assign bus.err_sticky      = 1'b0;
  assign bus.err_count       = '0;
  assign bus.last_err_addr   = '0;
  assign bus.last_err_status = 3'd0;
`endif

endmodule

// File: tb/tb_axi_addr_aligner.sv
// Self-checking bench for axi_addr_aligner: directed table sweep, stats
// scenarios and random traffic against a byte-arithmetic reference model.
module tb_axi_addr_aligner;
  localparam int AW = 32;
  localparam int CW = 4;
`ifdef ADDR_ALIGN_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axi_addr_aligner_if #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus ();

  axi_addr_aligner #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference statistics state.
  bit          m_sticky;
  int          m_cnt;
  logic [31:0] m_laddr;
  logic [2:0]  m_lst;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: a beat of 2^size bytes is legal when addr is a multiple of
  // that byte count; strobes cover those bytes starting at addr mod 4.
  function automatic void ref_comb(input logic [31:0] a, input logic [1:0] s,
                                   output bit ok, output logic [3:0] strb,
                                   output logic [2:0] st);
    int nbytes, off, mask;
    ok = 1'b0; strb = 4'b0; st = 3'd0;
    if (s == 2'd3) begin
      st = 3'd2;
    end else begin
      nbytes = 1 << s;
      off    = int'(a % 4);
      if (a % nbytes == 0) begin
        ok   = 1'b1;
        mask = ((1 << nbytes) - 1) << off;
        strb = mask[3:0];
      end else begin
        st = 3'd3;
      end
    end
  endfunction

  // One clock: drive, check combinational outputs, clock, check statistics.
  task automatic cycle(input logic [31:0] a, input logic [1:0] s,
                       input bit cv, input bit sc, input bit r);
    bit ok; logic [3:0] strb; logic [2:0] st;
    bus.addr = a; bus.size = s; bus.check_valid = cv; bus.stats_clear = sc;
    rst = r;
    #2;
    ref_comb(a, s, ok, strb, st);
    chk("addr_ok", {31'b0, bus.addr_ok}, {31'b0, ok});
    chk("wstrb", {28'b0, bus.wstrb}, {28'b0, strb});
    chk("status_code", {29'b0, bus.status_code}, {29'b0, st});
    @(posedge clk);
    if (STATS) begin
      if (r || sc) begin
        m_sticky = 0; m_cnt = 0; m_laddr = '0; m_lst = '0;
      end else if (cv && !ok) begin
        m_sticky = 1;
        if (m_cnt < (1 << CW) - 1) m_cnt++;
        m_laddr = a; m_lst = st;
      end
    end
    #1;
    chk("err_sticky", {31'b0, bus.err_sticky}, {31'b0, m_sticky});
    chk("err_count", {28'b0, bus.err_count}, m_cnt);
    chk("last_err_addr", bus.last_err_addr, m_laddr);
    chk("last_err_status", {29'b0, bus.last_err_status}, {29'b0, m_lst});
  endtask

  initial begin
    m_sticky = 0; m_cnt = 0; m_laddr = '0; m_lst = '0;
    bus.addr = '0; bus.size = '0; bus.check_valid = 0; bus.stats_clear = 0;
    rst = 1'b1;
    @(negedge clk);
    // Reset with a failing qualified check present: reset wins.
    cycle(32'h0000_0003, 2'd2, 1, 0, 1);
    cycle(32'h0, 2'd0, 0, 0, 1);

    // Full table sweep, qualified so failures also feed the statistics.
    for (int s = 0; s < 4; s++)
      for (int o = 0; o < 4; o++)
        cycle(32'h1000 | 32'(o), 2'(s), 1, 0, 0);
    cycle(32'h0, 2'd0, 0, 1, 0);

    // Named scenarios.
    cycle(32'h1003, 2'd0, 0, 0, 0);
    cycle(32'h1002, 2'd1, 0, 0, 0);
    cycle(32'h2001, 2'd2, 1, 0, 0);
    cycle(32'h0, 2'd3, 1, 0, 0);
    cycle(32'h0, 2'd3, 0, 0, 0);
    cycle(32'h3003, 2'd1, 1, 1, 0);   // clear drops same-cycle failure
    cycle(32'h4000, 2'd2, 1, 0, 0);   // legal qualified check: no change

    // Saturation: 2^CW+3 consecutive failures.
    for (int i = 0; i < (1 << CW) + 3; i++)
      cycle(32'h5000 + 32'(i * 4 + 1), 2'd2, 1, 0, 0);

    // Random traffic.
    for (int i = 0; i < 300; i++)
      cycle($urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 19) == 0), ($urandom_range(0, 49) == 0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
